// File: rtl/regfile_mp_if.sv
// Register-file port bundle: two read ports with busy flags, two write ports,
// issue marking, flush and the pending count. Master is the pipeline side.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wa_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              flush;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output rd_addr1, rd_addr2, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, pend_cnt
    );

    modport slave (
        input  rd_addr1, rd_addr2, wa_en, wa_addr, wa_data,
               wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, pend_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Purpose: 2-read/2-write register file with write bypass and pending scoreboard.
// Latency: reads and busy combinational; writes/pending visible from array next cycle.
// Backpressure: none; issue stage stalls on rd_busy, pend_cnt is registered.
module regfile_mp #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 5,
    parameter int unsigned RESET_VAL = 32'd10,
    parameter int          R0_ZERO   = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int              NREGS = 1 << ADDR_W;
    localparam bit              R0    = (R0_ZERO != 0);
    localparam logic [DATA_W-1:0] RST_W = DATA_W'(RESET_VAL);

    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  pend;
    logic [NREGS-1:0]  pend_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wa_ok;
    logic              wb_ok;
    logic              iss_ok;

    // Effective enables: nothing is accepted while reset is held, and
    // register 0 silently drops writes/issues when hard-wired to zero.
    assign wa_ok  = reset && bus.wa_en  && !(R0 && bus.wa_addr  == '0);
    assign wb_ok  = reset && bus.wb_en  && !(R0 && bus.wb_addr  == '0);
    assign iss_ok = reset && bus.iss_en && !(R0 && bus.iss_addr == '0);

    always_comb begin
        pend_nxt = pend;
        for (int r = 0; r < NREGS; r++) begin
            if (bus.flush)
                pend_nxt[r] = 1'b0;
            else if (iss_ok && bus.iss_addr == ADDR_W'(r))
                pend_nxt[r] = 1'b1;
            else if ((wa_ok && bus.wa_addr == ADDR_W'(r)) ||
                     (wb_ok && bus.wb_addr == ADDR_W'(r)))
                pend_nxt[r] = 1'b0;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NREGS; r++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[r]);
    end

    // Port B is written last so it wins a same-address collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= (R0 && i == 0) ? '0 : RST_W;
            pend         <= '0;
            bus.pend_cnt <= '0;
        end else begin
            if (wa_ok)
                mem[bus.wa_addr] <= bus.wa_data;
            if (wb_ok)
                mem[bus.wb_addr] <= bus.wb_data;
            pend         <= pend_nxt;
            bus.pend_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        bus.rd_data1 = mem[bus.rd_addr1];
        if (wa_ok && bus.wa_addr == bus.rd_addr1)
            bus.rd_data1 = bus.wa_data;
        if (wb_ok && bus.wb_addr == bus.rd_addr1)
            bus.rd_data1 = bus.wb_data;
        if (R0 && bus.rd_addr1 == '0)
            bus.rd_data1 = '0;
    end

    always_comb begin
        bus.rd_data2 = mem[bus.rd_addr2];
        if (wa_ok && bus.wa_addr == bus.rd_addr2)
            bus.rd_data2 = bus.wa_data;
        if (wb_ok && bus.wb_addr == bus.rd_addr2)
            bus.rd_data2 = bus.wb_data;
        if (R0 && bus.rd_addr2 == '0)
            bus.rd_data2 = '0;
    end

    // A writeback landing this cycle is forwarded, so it no longer blocks.
    assign bus.rd_busy1 = pend[bus.rd_addr1] &&
                          !((wa_ok && bus.wa_addr == bus.rd_addr1) ||
                            (wb_ok && bus.wb_addr == bus.rd_addr1));
    assign bus.rd_busy2 = pend[bus.rd_addr2] &&
                          !((wa_ok && bus.wa_addr == bus.rd_addr2) ||
                            (wb_ok && bus.wb_addr == bus.rd_addr2));
endmodule
